// File: rtl/board_cursor_decoder_if.sv
// Mouse-side bus of the board cursor decoder: relative moves and button in,
// clamped cursor position and decoded board cell out.
interface board_cursor_decoder_if;
  logic              move_valid;
  logic signed [8:0] dx;
  logic signed [8:0] dy;
  logic              button_in;
  logic [7:0]        cursor_px;
  logic [6:0]        cursor_py;
  logic [2:0]        mouse_x;
  logic [2:0]        mouse_y;
  logic              on_board;
  logic              cell_valid;
  logic              click;

  modport master (
    output move_valid, dx, dy, button_in,
    input  cursor_px, cursor_py, mouse_x, mouse_y, on_board, cell_valid, click
  );

  modport slave (
    input  move_valid, dx, dy, button_in,
    output cursor_px, cursor_py, mouse_x, mouse_y, on_board, cell_valid, click
  );
endinterface

// File: rtl/board_cursor_decoder.sv
// Tracks a clamped mouse cursor and decodes it into an 8x8 board cell by
// iterative subtraction of the cell pitch, one axis per lane.

// One axis lane: clamped position plus a remainder/quotient divider.
module board_cursor_axis #(
  parameter int PW     = 8,
  parameter int MAXV   = 159,
  parameter int INIT   = 80,
  parameter int CELL   = 17,
  parameter int ORIGIN = 1,
  parameter int GRID   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_i,
  input  logic               div_i,
  input  logic [9:0]         delta_i,
  output logic [PW-1:0]      pos_o,
  output logic signed [10:0] rem_nx_o,
  output logic [3:0]         quo_nx_o,
  output logic               more_o
);
  localparam logic signed [11:0] MAX_S  = 12'(MAXV);
  localparam logic signed [10:0] CELL_S = 11'(CELL);
  localparam logic signed [10:0] ORG_S  = 11'(ORIGIN);
  localparam logic [3:0]         GRID_Q = 4'(GRID);

  logic [PW-1:0]      pos_q, pos_d;
  logic signed [10:0] rem_q, rem_d;
  logic [3:0]         quo_q, quo_d;
  logic signed [11:0] sum;

  always_comb begin
    pos_d = pos_q;
    rem_d = rem_q;
    quo_d = quo_q;
    sum   = $signed(12'(pos_q)) + $signed({{2{delta_i[9]}}, delta_i});
    if (ld_i) begin
      if (sum < 12'sd0)       pos_d = '0;
      else if (sum > MAX_S)   pos_d = MAX_S[PW-1:0];
      else                    pos_d = sum[PW-1:0];
      rem_d = $signed(11'(pos_d)) - ORG_S;
      quo_d = '0;
    end else if (div_i && rem_q >= CELL_S && quo_q < GRID_Q) begin
      rem_d = rem_q - CELL_S;
      quo_d = quo_q + 4'd1;
    end
  end

  // Look-ahead stop so the last subtracting cycle is also the last DIV cycle.
  assign more_o   = (rem_d >= CELL_S) && (quo_d < GRID_Q);
  assign pos_o    = pos_q;
  assign rem_nx_o = rem_d;
  assign quo_nx_o = quo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= PW'(INIT);
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      pos_q <= pos_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end
endmodule

module board_cursor_decoder #(
  parameter int CELL   = 17,
  parameter int ORIGIN = 1,
  parameter int GRID   = 8,
  parameter int SCR_W  = 160,
  parameter int SCR_H  = 120
) (
  input logic                   clk,
  input logic                   reset,
  board_cursor_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_e;

  localparam logic signed [10:0] LAST_S = 11'(CELL - 2);
  localparam logic [3:0]         GRID_Q = 4'(GRID);

  state_e               state_q, state_d;
  logic [1:0][9:0]      pend_q, pend_d;
  logic                 pend_flag_q, pend_flag_d;
  logic [1:0][2:0]      mouse_q, mouse_d;
  logic                 on_board_q, on_board_d;
  logic                 cell_valid_q, cell_valid_d;
  logic                 click_q, click_d;
  logic                 click_pend_q, click_pend_d;
  logic                 btn_q;
  logic [1:0][8:0]      mv;
  logic [1:0][10:0]     rem_nx;
  logic [1:0][3:0]      quo_nx;
  logic [1:0]           more;
  logic                 ld, dv;

  assign mv[0] = bus.dx;
  assign mv[1] = bus.dy;
  assign ld    = (state_q == ACCUM);
  assign dv    = (state_q == DIV);

  for (genvar g = 0; g < 2; g++) begin : g_ax
    localparam int PW   = (g == 0) ? 8 : 7;
    localparam int MAXV = (g == 0) ? SCR_W - 1 : SCR_H - 1;
    localparam int INIT = (g == 0) ? SCR_W / 2 : SCR_H / 2;
    logic [PW-1:0] pos;
    board_cursor_axis #(
      .PW(PW), .MAXV(MAXV), .INIT(INIT), .CELL(CELL), .ORIGIN(ORIGIN), .GRID(GRID)
    ) u_ax (
      .clk      (clk),
      .reset    (reset),
      .ld_i     (ld),
      .div_i    (dv),
      .delta_i  (pend_q[g]),
      .pos_o    (pos),
      .rem_nx_o (rem_nx[g]),
      .quo_nx_o (quo_nx[g]),
      .more_o   (more[g])
    );
    if (g == 0) begin : g_x
      assign bus.cursor_px = pos;
    end else begin : g_y
      assign bus.cursor_py = pos;
    end
  end

  function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [8:0] b);
    logic signed [10:0] s;
    s = $signed({a[9], a}) + $signed({{2{b[8]}}, b});
    if (s > 11'sd511)       return 10'h1FF;
    else if (s < -11'sd511) return 10'h201;
    else                    return s[9:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_flag_d  = pend_flag_q;
    click_pend_d = click_pend_q;
    click_d      = 1'b0;
    cell_valid_d = 1'b0;
    on_board_d   = 1'b1;
    for (int g = 0; g < 2; g++) begin
      mouse_d[g] = quo_nx[g][2:0];
      if ($signed(rem_nx[g]) < 11'sd0 || $signed(rem_nx[g]) > LAST_S || quo_nx[g] >= GRID_Q)
        on_board_d = 1'b0;
    end

    // ACCUM consumes the pending sum; a move arriving that cycle starts a new one.
    if (state_q == ACCUM) begin
      pend_d      = '0;
      pend_flag_d = 1'b0;
    end
    if (bus.move_valid) begin
      for (int g = 0; g < 2; g++) pend_d[g] = sat_add(pend_d[g], mv[g]);
      pend_flag_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (click_pend_q) begin
          click_d      = on_board_q;
          click_pend_d = 1'b0;
        end else if (bus.move_valid || pend_flag_q) begin
          state_d = ACCUM;
        end
      end
      ACCUM: state_d = DIV;
      DIV: begin
        if (!more[0] && !more[1]) begin
          state_d      = DONE;
          cell_valid_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
    endcase

    if (bus.button_in && !btn_q) click_pend_d = 1'b1;
  end

  // Reset parks the FSM in ACCUM so a start-up decode follows release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCUM;
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
      mouse_q      <= '0;
      on_board_q   <= 1'b0;
      cell_valid_q <= 1'b0;
      click_q      <= 1'b0;
      click_pend_q <= 1'b0;
      btn_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      cell_valid_q <= cell_valid_d;
      click_q      <= click_d;
      click_pend_q <= click_pend_d;
      btn_q        <= bus.button_in;
      if (cell_valid_d) begin
        mouse_q    <= mouse_d;
        on_board_q <= on_board_d;
      end
    end
  end

  assign bus.mouse_x    = mouse_q[0];
  assign bus.mouse_y    = mouse_q[1];
  assign bus.on_board   = on_board_q;
  assign bus.cell_valid = cell_valid_q;
  assign bus.click      = click_q;
endmodule
